// File: rtl/simp_mem_unit_if.sv
// simp_mem_unit_if
//   Bundles the CPU request/acknowledge port and the side loader port of the
//   SIMPCOMP main memory. Clock and reset stay outside as plain ports.
//   Signals (master = CPU/loader side, slave = memory side):
//     Req      master->slave  transaction request level
//     Wr       master->slave  1 = write, 0 = read (sampled with Req)
//     MAR      master->slave  transaction address
//     MBR_in   master->slave  write data
//     MBR_out  slave->master  read data, held until next completed read
//     Ack      slave->master  one-cycle completion pulse
//     AddrErr  slave->master  one-cycle pulse with Ack for an out-of-range address
//     Busy     slave->master  transaction in flight
//     LdEn     master->slave  loader write strobe
//     LdAddr   master->slave  loader address
//     LdData   master->slave  loader data
interface simp_mem_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic              Req;
    logic              Wr;
    logic [ADDR_W-1:0] MAR;
    logic [DATA_W-1:0] MBR_in;
    logic [DATA_W-1:0] MBR_out;
    logic              Ack;
    logic              AddrErr;
    logic              Busy;
    logic              LdEn;
    logic [ADDR_W-1:0] LdAddr;
    logic [DATA_W-1:0] LdData;

    modport master (
        output Req, Wr, MAR, MBR_in, LdEn, LdAddr, LdData,
        input  MBR_out, Ack, AddrErr, Busy
    );

    modport slave (
        input  Req, Wr, MAR, MBR_in, LdEn, LdAddr, LdData,
        output MBR_out, Ack, AddrErr, Busy
    );
endinterface

// File: rtl/simp_mem_unit.sv
// simp_mem_unit
//   Word-addressed main memory serving SIMPCOMP MAR/MBR traffic through one
//   request/acknowledge port with WAIT_STATES extra cycles per transaction,
//   plus a loader port for filling memory while the port is idle.
//   Ports:
//     Clk    rising-edge system clock
//     Reset  synchronous active-high; clears control state only, not memory
//     bus    simp_mem_unit_if.slave (Req/Wr/MAR/MBR_in/MBR_out/Ack/AddrErr/
//            Busy/LdEn/LdAddr/LdData)
//   All outputs are registered.
module simp_mem_unit #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    simp_mem_unit_if.slave   bus
);

    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      LAST    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] mbr_out;
    logic              ack;
    logic              addr_err;
    logic              busy;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              finish;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_wr;
    logic [DATA_W-1:0] acc_data;
    logic              in_range;
    logic              ld_in_range;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign bus.MBR_out = mbr_out;
    assign bus.Ack     = ack;
    assign bus.AddrErr = addr_err;
    assign bus.Busy    = busy;

    // With zero wait states the access completes at the accepting edge, so the
    // transaction fields come straight from the port; otherwise from the latch.
    always_comb begin
        accept      = (state == S_IDLE) && bus.Req && !bus.LdEn;
        acc_addr    = (state == S_IDLE) ? bus.MAR    : lat_addr;
        acc_wr      = (state == S_IDLE) ? bus.Wr     : lat_wr;
        acc_data    = (state == S_IDLE) ? bus.MBR_in : lat_data;
        finish      = ((state == S_WAIT) && (cnt == LAST)) ||
                      (accept && (WAIT_STATES == 0));
        in_range    = {1'b0, acc_addr} < DEPTH_L;
        ld_in_range = {1'b0, bus.LdAddr} < DEPTH_L;
        rd_data     = mem[acc_addr[IDX_W-1:0]];

        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!Reset) begin
            if ((state == S_IDLE) && bus.LdEn) begin
                if (ld_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.LdAddr[IDX_W-1:0];
                    mem_wdata = bus.LdData;
                end
            end else if (finish && acc_wr && in_range) begin
                mem_we    = 1'b1;
                mem_waddr = acc_addr[IDX_W-1:0];
                mem_wdata = acc_data;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            mbr_out  <= '0;
            ack      <= 1'b0;
            addr_err <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ack      <= 1'b0;
            addr_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_addr <= bus.MAR;
                        lat_wr   <= bus.Wr;
                        lat_data <= bus.MBR_in;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            // Ack/AddrErr and read data are registered at the edge entering DONE.
            if (finish) begin
                ack      <= 1'b1;
                addr_err <= !in_range;
                if (!acc_wr) begin
                    mbr_out <= in_range ? rd_data : '0;
                end
            end
        end
    end

endmodule
